// File: rtl/data_memory.sv
// Word-addressed synchronous data memory with strobe edge detection
// and a fixed, parameterized access latency.
module data_memory #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [DATA_W-1:0] dataOut,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_prev_q, wr_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              is_wr_q, is_wr_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q;
    logic              rd_edge, wr_edge;
    logic              go_resp;

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_edge = memRead & ~rd_prev_q;
    assign wr_edge = memWrite & ~wr_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        is_wr_d = is_wr_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_edge ^ wr_edge) begin
                    addr_d  = addr;
                    data_d  = dataIn;
                    is_wr_d = wr_edge;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (rd_edge & wr_edge) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The array is touched only on the edge that enters RESP, using the
    // next-state bundle so LATENCY==1 works straight from IDLE.
    assign go_resp = (state_d == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_prev_q <= memRead;
            wr_prev_q <= memWrite;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
            if (go_resp && !is_wr_d) begin
                dout_q <= mem[addr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && go_resp && is_wr_d) begin
            mem[addr_d] <= data_d;
        end
    end

    assign dataOut = dout_q;
    assign ready   = (state_q == RESP);
    assign busy    = (state_q != IDLE);
    assign err     = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory at LATENCY 2 and 1, with an
// expected-read-data queue popped on every ready pulse.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic [15:0] dataIn;
    logic        memRead;
    logic        memWrite;

    logic [15:0] d2_dout, d1_dout;
    logic        d2_ready, d2_busy, d2_err;
    logic        d1_ready, d1_busy, d1_err;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  b2b_addr [3];
    logic [15:0] b2b_data [3];

    always #5 clk = ~clk;

    data_memory #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .addr(addr), .dataIn(dataIn),
        .memRead(memRead), .memWrite(memWrite), .dataOut(d2_dout),
        .ready(d2_ready), .busy(d2_busy), .err(d2_err)
    );

    data_memory #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .addr(addr), .dataIn(dataIn),
        .memRead(memRead), .memWrite(memWrite), .dataOut(d1_dout),
        .ready(d1_ready), .busy(d1_busy), .err(d1_err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One strobe pulse, then watch the selected instance for 6 cycles.
    task automatic access(input bit sel, input bit wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [15:0] exp_out,
                          input string tag);
        int rdy_at = 0;
        int busy_n = 0;
        int rdy_n  = 0;
        int lat    = sel ? 1 : 2;
        addr   = a;
        dataIn = d;
        if (wr) memWrite = 1'b1;
        else    memRead  = 1'b1;
        exp_q.push_back(exp_out);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
            if (sel ? d1_busy : d2_busy) busy_n++;
            if (sel ? d1_ready : d2_ready) begin
                rdy_n++;
                rdy_at = i;
                if (exp_q.size() > 0)
                    check({tag, "_data"}, sel ? d1_dout : d2_dout,
                          exp_q.pop_front());
            end
        end
        check({tag, "_ready_at"}, rdy_at, lat);
        check({tag, "_busy_cycles"}, busy_n, lat);
        check({tag, "_ready_pulses"}, rdy_n, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        b2b_addr = '{8'h00, 8'hFF, 8'h00};
        b2b_data = '{16'h1111, 16'h2222, 16'h1111};
        reset    = 1'b1;
        addr     = '0;
        dataIn   = '0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_dout", d2_dout, 16'h0);
        check("rst_ready", d2_ready, 1'b0);
        check("rst_busy", d2_busy, 1'b0);
        check("rst_err", d2_err, 1'b0);
        check("rst_dout_l1", d1_dout, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_busy", d2_busy, 1'b0);
            check("idle_ready", d2_ready, 1'b0);
        end

        access(0, 1, 8'h12, 16'hBEEF, 16'h0000, "wr12");
        access(0, 0, 8'h12, 16'h0000, 16'hBEEF, "rd12");

        addr     = 8'h12;
        dataIn   = 16'h0000;
        memRead  = 1'b1;
        memWrite = 1'b1;
        step();
        check("both_err", d2_err, 1'b1);
        check("both_busy", d2_busy, 1'b0);
        memRead  = 1'b0;
        memWrite = 1'b0;
        step();
        check("both_err_clr", d2_err, 1'b0);
        check("both_busy2", d2_busy, 1'b0);
        step();
        access(0, 0, 8'h12, 16'h0000, 16'hBEEF, "rd12b");

        access(0, 1, 8'h05, 16'h0555, 16'hBEEF, "wr05");
        access(0, 1, 8'h07, 16'h0666, 16'hBEEF, "wr07");
        addr    = 8'h05;
        memRead = 1'b1;
        exp_q.push_back(16'h0555);
        step();
        check("hold_busy", d2_busy, 1'b1);
        addr     = 8'h07;
        dataIn   = 16'h7777;
        memWrite = 1'b1;
        step();
        check("hold_ready", d2_ready, 1'b1);
        check("hold_data", d2_dout, exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_no_busy", d2_busy, 1'b0);
            check("hold_no_ready", d2_ready, 1'b0);
        end
        memRead  = 1'b0;
        memWrite = 1'b0;
        step();
        access(0, 0, 8'h07, 16'h0000, 16'h0666, "rd07");
        access(0, 1, 8'h07, 16'h7777, 16'h0666, "wr07b");
        access(0, 0, 8'h07, 16'h0000, 16'h7777, "rd07b");

        access(0, 1, 8'h40, 16'h0AAA, 16'h7777, "wr40");
        addr     = 8'h40;
        dataIn   = 16'h1234;
        memWrite = 1'b1;
        step();
        check("rstw_busy", d2_busy, 1'b1);
        reset    = 1'b1;
        memWrite = 1'b0;
        step();
        check("rstw_ready", d2_ready, 1'b0);
        check("rstw_busy_clr", d2_busy, 1'b0);
        check("rstw_dout", d2_dout, 16'h0);
        reset = 1'b0;
        step();
        check("rstw_ready2", d2_ready, 1'b0);
        access(0, 0, 8'h40, 16'h0000, 16'h0AAA, "rd40");

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        access(1, 1, 8'h00, 16'h1111, 16'h0000, "l1wr00");
        access(1, 1, 8'hFF, 16'h2222, 16'h0000, "l1wrff");
        for (int k = 0; k < 3; k++) begin
            addr    = b2b_addr[k];
            memRead = 1'b1;
            exp_q.push_back(b2b_data[k]);
            step();
            check("b2b_ready", d1_ready, 1'b1);
            if (d1_ready && exp_q.size() > 0)
                check("b2b_data", d1_dout, exp_q.pop_front());
            memRead = 1'b0;
            step();
            check("b2b_ready_low", d1_ready, 1'b0);
        end
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
